bash_hash_ctrl: RTL

- Upstream sponge controller for the bash_hash core.
- Accepts a byte-granular message stream over valid/ready, packs it into rate-sized blocks, applies bash padding, and sequences the core's prep/start/work/first controls (one block = 1 start cycle + NR work cycles).
- Presents the truncated digest (2l bits) on a valid/ready output.

---
 rtl/bash_hash_params_pkg.sv | 35 +++
 rtl/bash_hash_pad_word.sv | 21 ++
 rtl/bash_hash_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/bash_hash_params_pkg.sv
// Shared widths, controller state type and helpers for the bash_hash sponge controller.
package bash_hash_params_pkg;

    localparam int SLEN = 64;
    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        START = 3'd2,
        WORK  = 3'd3,
        PAD   = 3'd4,
        DONE  = 3'd5
    } ctrl_state_e;

    localparam logic [7:0] PAD_BYTE = 8'h40;

    // Unknown security levels fall back to the l=256 geometry.
    function automatic logic [4:0] rate_words(input logic [XLEN-1:0] l);
        case (l)
            32'd128: rate_words = 5'd16;
            32'd192: rate_words = 5'd12;
            default: rate_words = 5'd8;
        endcase
    endfunction

    function automatic logic [3:0] hash_words(input logic [XLEN-1:0] l);
        case (l)
            32'd128: hash_words = 4'd4;
            32'd192: hash_words = 4'd6;
            default: hash_words = 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/bash_hash_pad_word.sv
// Keeps the low bytes_i bytes of a word, places the 0x40 pad marker after them, zeroes the rest.
module bash_hash_pad_word
    import bash_hash_params_pkg::*;
(
    input  logic [SLEN-1:0] data_i,
    input  logic [3:0]      bytes_i,
    output logic [SLEN-1:0] word_o
);

    always_comb begin
        word_o = '0;
        for (int b = 0; b < 8; b++) begin
            if (4'(b) < bytes_i) begin
                word_o[8*b +: 8] = data_i[8*b +: 8];
            end else if (4'(b) == bytes_i) begin
                word_o[8*b +: 8] = PAD_BYTE;
            end
        end
    end

endmodule

// File: rtl/bash_hash_ctrl.sv
// Sponge controller: packs message beats into rate blocks, pads, sequences the bash core.
// Optional BASH_HASH_CTRL_PERF_EN adds block and busy-cycle counters.
module bash_hash_ctrl
    import bash_hash_params_pkg::*;
#(
    parameter int NR     = 24,
    parameter int RCNT_W = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [XLEN-1:0]      l_i,
    input  logic                 msg_valid_i,
    output logic                 msg_ready_o,
    input  logic [SLEN-1:0]      msg_data_i,
    input  logic                 msg_last_i,
    input  logic [3:0]           msg_bytes_i,
    output logic [16*SLEN-1:0]   x_o,
    output logic [XLEN-1:0]      l_o,
    output logic                 prep_o,
    output logic                 start_o,
    output logic                 work_o,
    output logic                 first_o,
    input  logic [8*SLEN-1:0]    y_i,
    output logic                 hash_valid_o,
    input  logic                 hash_ready_i,
    output logic [8*SLEN-1:0]    hash_o
`ifdef BASH_HASH_CTRL_PERF_EN
    ,
    output logic [15:0]          blk_cnt_o,
    output logic [31:0]          busy_cyc_o
`endif
);

    ctrl_state_e        state_q;
    logic [SLEN-1:0]    blk_q [16];
    logic [4:0]         idx_q;
    logic [RCNT_W-1:0]  rcnt_q;
    logic [XLEN-1:0]    l_q;
    logic               first_blk_q, pad_pend_q, msg_done_q;
    logic               ready_q, start_q, first_q, work_q, hv_q;

    logic               beat;
    logic [4:0]         r_cur, r_lat, wr_idx, idx_n;
    logic [SLEN-1:0]    pad_data, beat_word;
    logic [3:0]         pad_bytes;

    assign beat   = msg_valid_i & ready_q;
    assign r_cur  = (state_q == IDLE) ? rate_words(l_i) : rate_words(l_q);
    assign r_lat  = rate_words(l_q);
    assign wr_idx = (state_q == IDLE) ? 5'd0 : idx_q;
    assign idx_n  = wr_idx + 5'd1;

    // The PAD state reuses the same padder with an empty word to get word0 = 0x40.
    assign pad_data  = (state_q == PAD) ? '0 : msg_data_i;
    assign pad_bytes = (state_q == PAD) ? 4'd0 : (msg_last_i ? msg_bytes_i : 4'd8);

    bash_hash_pad_word u_pad (
        .data_i  (pad_data),
        .bytes_i (pad_bytes),
        .word_o  (beat_word)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            for (int k = 0; k < 16; k++) blk_q[k] <= '0;
            idx_q       <= '0;
            rcnt_q      <= '0;
            l_q         <= '0;
            first_blk_q <= 1'b0;
            pad_pend_q  <= 1'b0;
            msg_done_q  <= 1'b0;
            ready_q     <= 1'b0;
            start_q     <= 1'b0;
            first_q     <= 1'b0;
            work_q      <= 1'b0;
            hv_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE, FILL: begin
                    if (state_q == IDLE) ready_q <= 1'b1;
                    if (beat) begin
                        blk_q[wr_idx[3:0]] <= beat_word;
                        idx_q <= idx_n;
                        if (state_q == IDLE) begin
                            l_q         <= l_i;
                            first_blk_q <= 1'b1;
                        end
                        if (msg_last_i || idx_n == r_cur) begin
                            if (msg_last_i) begin
                                msg_done_q <= 1'b1;
                                // Full last word: marker goes into the next word, or a whole extra block.
                                if (msg_bytes_i >= 4'd8) begin
                                    if (idx_n < r_cur) blk_q[idx_n[3:0]] <= {{(SLEN-8){1'b0}}, PAD_BYTE};
                                    else               pad_pend_q <= 1'b1;
                                end
                            end
                            state_q <= START;
                            start_q <= 1'b1;
                            first_q <= (state_q == IDLE) ? 1'b1 : first_blk_q;
                            ready_q <= 1'b0;
                        end else begin
                            state_q <= FILL;
                        end
                    end
                end
                START: begin
                    start_q     <= 1'b0;
                    first_q     <= 1'b0;
                    first_blk_q <= 1'b0;
                    work_q      <= 1'b1;
                    rcnt_q      <= '0;
                    state_q     <= WORK;
                end
                WORK: begin
                    if (rcnt_q == RCNT_W'(NR - 1)) begin
                        work_q <= 1'b0;
                        if (pad_pend_q) begin
                            state_q <= PAD;
                        end else if (!msg_done_q) begin
                            for (int k = 0; k < 16; k++) blk_q[k] <= '0;
                            idx_q   <= '0;
                            ready_q <= 1'b1;
                            state_q <= FILL;
                        end else begin
                            hv_q    <= 1'b1;
                            state_q <= DONE;
                        end
                    end else begin
                        rcnt_q <= rcnt_q + RCNT_W'(1);
                    end
                end
                PAD: begin
                    for (int k = 0; k < 16; k++) blk_q[k] <= '0;
                    blk_q[0]   <= beat_word;
                    pad_pend_q <= 1'b0;
                    start_q    <= 1'b1;
                    first_q    <= first_blk_q;
                    state_q    <= START;
                end
                DONE: begin
                    if (hash_ready_i) begin
                        for (int k = 0; k < 16; k++) blk_q[k] <= '0;
                        hv_q       <= 1'b0;
                        ready_q    <= 1'b1;
                        msg_done_q <= 1'b0;
                        idx_q      <= '0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < 16; k++) begin : g_x
        assign x_o[SLEN*k +: SLEN] = (5'(k) < r_lat) ? blk_q[k] : '0;
    end

    for (genvar k = 0; k < 8; k++) begin : g_h
        assign hash_o[SLEN*k +: SLEN] = (hv_q && 4'(k) < hash_words(l_q)) ? y_i[SLEN*k +: SLEN] : '0;
    end

    assign msg_ready_o  = ready_q;
    assign l_o          = l_q;
    assign start_o      = start_q;
    assign prep_o       = first_q;
    assign first_o      = first_q;
    assign work_o       = work_q;
    assign hash_valid_o = hv_q;

`ifdef BASH_HASH_CTRL_PERF_EN
    logic [15:0] blk_cnt_q;
    logic [31:0] busy_cyc_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            blk_cnt_q  <= '0;
            busy_cyc_q <= '0;
        end else begin
            if (state_q == IDLE && beat)               blk_cnt_q <= '0;
            else if (start_q && blk_cnt_q != 16'hFFFF) blk_cnt_q <= blk_cnt_q + 16'd1;
            if (state_q != IDLE && busy_cyc_q != 32'hFFFF_FFFF) busy_cyc_q <= busy_cyc_q + 32'd1;
        end
    end

    assign blk_cnt_o  = blk_cnt_q;
    assign busy_cyc_o = busy_cyc_q;
`endif

endmodule
